// File: rtl/fir_decimator_pkg.sv
// Shared types and width helpers for the fir_decimator integrate-and-dump stage.
package fir_decimator_pkg;

  typedef enum logic {S_SKIP, S_ACCUM} state_t;

  // A full frame of D samples needs DEC_LOG2 extra bits of headroom.
  function automatic int acc_w(int bw_in, int dec_log2);
    return bw_in + dec_log2;
  endfunction

  function automatic int scale_sh(int bw_in, int bw_out, int dec_log2);
    return dec_log2 + bw_in - bw_out;
  endfunction

  function automatic int skip_w(int skip);
    return (skip > 0) ? $clog2(skip + 1) : 1;
  endfunction

endpackage

// File: rtl/fir_dec_scale.sv
// Combinational scaling of a full frame sum to the output width.
// Define FIR_DECIMATOR_ROUND_EN for round-half-up with positive saturation.
module fir_dec_scale
  import fir_decimator_pkg::*;
#(
  parameter int BW_in    = 8,
  parameter int BW_out   = 8,
  parameter int DEC_LOG2 = 2
) (
  input  logic signed [acc_w(BW_in, DEC_LOG2)-1:0] sum,
  output logic signed [BW_out-1:0]                 y
);

  localparam int ACC_W = acc_w(BW_in, DEC_LOG2);
  localparam int SH    = scale_sh(BW_in, BW_out, DEC_LOG2);

`ifdef FIR_DECIMATOR_ROUND_EN
  localparam int RND_I = (SH > 0) ? (1 << ((SH > 0) ? SH - 1 : 0)) : 0;
  localparam logic signed [ACC_W:0] RND_TERM = (ACC_W+1)'(RND_I);
  localparam logic signed [ACC_W:0] MAX_OUT  = (ACC_W+1)'((1 << (BW_out - 1)) - 1);

  logic signed [ACC_W:0] t;

  // The rounding term can only push a value upward, so only the positive limit needs a clamp.
  always_comb begin
    t = ((ACC_W+1)'(sum) + RND_TERM) >>> SH;
    y = (t > MAX_OUT) ? BW_out'(MAX_OUT) : BW_out'(t);
  end
`else
  always_comb begin
    y = BW_out'(sum >>> SH);
  end
`endif

endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: drops SKIP warm-up samples, then averages frames of D samples.
// Rounding/saturation is selected in fir_dec_scale via FIR_DECIMATOR_ROUND_EN.
module fir_decimator
  import fir_decimator_pkg::*;
#(
  parameter int BW_in    = 8,
  parameter int BW_out   = 8,
  parameter int DEC_LOG2 = 2,
  parameter int SKIP     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [BW_in-1:0]  x_in,
  input  logic                     in_valid,
  input  logic                     restart,
  output logic signed [BW_out-1:0] y_out,
  output logic                     out_valid,
  output logic [DEC_LOG2-1:0]      phase
);

  localparam int ACC_W  = acc_w(BW_in, DEC_LOG2);
  localparam int SKIP_W = skip_w(SKIP);

  state_t                   state;
  logic [SKIP_W-1:0]        skip_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [BW_out-1:0] scaled;

  assign x_ext    = ACC_W'(x_in);
  assign sum_next = acc + x_ext;

  fir_dec_scale #(
    .BW_in    (BW_in),
    .BW_out   (BW_out),
    .DEC_LOG2 (DEC_LOG2)
  ) u_scale (
    .sum (sum_next),
    .y   (scaled)
  );

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (SKIP == 0) ? S_ACCUM : S_SKIP;
      skip_cnt  <= '0;
      acc       <= '0;
      phase     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_SKIP: begin
          if (in_valid) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
            if (skip_cnt == SKIP_W'(SKIP - 1)) state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // restart wins over frame completion: the partial frame is never emitted.
          if (restart) begin
            acc   <= in_valid ? x_ext : '0;
            phase <= in_valid ? DEC_LOG2'(1) : '0;
          end else if (in_valid) begin
            if (&phase) begin
              y_out     <= scaled;
              out_valid <= 1'b1;
              acc       <= '0;
              phase     <= '0;
            end else begin
              acc   <= sum_next;
              phase <= phase + DEC_LOG2'(1);
            end
          end
        end
        default: state <= S_SKIP;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: frame table plus hand-written corner sequences,
// strobes checked against a queue of expected outputs.
module tb_fir_decimator;

`ifdef FIR_DECIMATOR_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] x_in;
  logic              in_valid;
  logic              restart;
  logic signed [7:0] y_out;
  logic              out_valid;
  logic [1:0]        phase;
  logic signed [6:0] y_s;
  logic              ov_s;
  logic [1:0]        phase_s;

  int tests  = 0;
  int fails  = 0;
  int exp_q[$];

  typedef struct {
    string name;
    int    x [4];
    int    expv;
    bit    chk_sat;
    int    sat_exp;
  } frame_t;

  frame_t tbl [6];

  fir_decimator #(.BW_in(8), .BW_out(8), .DEC_LOG2(2), .SKIP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .restart   (restart),
    .y_out     (y_out),
    .out_valid (out_valid),
    .phase     (phase)
  );

  // Narrower output instance exercises positive saturation and negative full scale.
  fir_decimator #(.BW_in(8), .BW_out(7), .DEC_LOG2(2), .SKIP(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .restart   (restart),
    .y_out     (y_s),
    .out_valid (ov_s),
    .phase     (phase_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int x, input bit r);
    in_valid = v;
    x_in     = 8'(x);
    restart  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    x_in     = 8'sd33;
    restart  = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0; restart = 1'b0;

    tbl[0] = '{name:"neg_round", x:'{-1, -2, -2, -1},     expv:(RND ? -1 : -2), chk_sat:1'b0, sat_exp:0};
    tbl[1] = '{name:"pos_max",   x:'{127, 127, 127, 127}, expv:127,             chk_sat:1'b1, sat_exp:63};
    tbl[2] = '{name:"neg_min",   x:'{-128, -128, -128, -128}, expv:-128,        chk_sat:1'b1, sat_exp:-64};
    tbl[3] = '{name:"small_pos", x:'{1, 1, 1, 0},         expv:(RND ? 1 : 0),   chk_sat:1'b0, sat_exp:0};
    tbl[4] = '{name:"mixed",     x:'{100, -100, 7, -6},   expv:0,               chk_sat:1'b0, sat_exp:0};
    tbl[5] = '{name:"neg_half",  x:'{-3, -4, -5, -6},     expv:(RND ? -4 : -5), chk_sat:1'b0, sat_exp:0};

    // Scoreboard monitor and watchdog run alongside the stimulus.
    fork
      begin
        bit prev_ov = 1'b0;
        forever begin
          @(negedge clk);
          if (out_valid) begin
            if (prev_ov) check("back_to_back_strobe", 1, 0);
            if (exp_q.size() == 0) check("unexpected_strobe", int'(y_out), 999);
            else check("strobe_y_out", int'(y_out), exp_q.pop_front());
          end
          prev_ov = out_valid;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_y_out", int'(y_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_phase", int'(phase), 0);

    // Warm-up: four discarded samples, then a 10..40 frame averaging to 25.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 99, 1'b0);
      check("warmup_skip_phase", int'(phase), 0);
    end
    drive(1'b1, 10, 1'b0); check("warmup_phase1", int'(phase), 1);
    drive(1'b1, 20, 1'b0); check("warmup_phase2", int'(phase), 2);
    drive(1'b1, 30, 1'b0); check("warmup_phase3", int'(phase), 3);
    exp_q.push_back(25);
    drive(1'b1, 40, 1'b0);
    check("warmup_phase_wrap", int'(phase), 0);
    check("warmup_out_valid", int'(out_valid), 1);
    drain("warmup");

    // Continuous frames from the table.
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 3) exp_q.push_back(tbl[f].expv);
        drive(1'b1, tbl[f].x[j], 1'b0);
        check({tbl[f].name, "_phase"}, int'(phase), (j + 1) % 4);
      end
      if (tbl[f].chk_sat) begin
        check({tbl[f].name, "_sat_valid"}, int'(ov_s), 1);
        check({tbl[f].name, "_sat_y"}, int'(y_s), tbl[f].sat_exp);
      end
      drain(tbl[f].name);
    end

    // Valid gaps: strobe only on the 4th valid edge, outputs hold while idle.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(8);
      drive(1'b1, 8, 1'b0);
      check("gap_valid_edge_ov", int'(out_valid), (k == 3) ? 1 : 0);
      drive(1'b0, 0, 1'b0);
      check("gap_idle_ov", int'(out_valid), 0);
      check("gap_idle_phase", int'(phase), (k + 1) % 4);
    end
    drain("gaps");
    drive(1'b0, 0, 1'b0);
    check("gap_hold_y", int'(y_out), 8);
    check("gap_hold_ov", int'(out_valid), 0);

    // restart with valid reseeds the frame; the 5,5 partial is never emitted.
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 4, 1'b1);
    check("restart_valid_phase", int'(phase), 1);
    drive(1'b1, 4, 1'b0);
    drive(1'b1, 4, 1'b0);
    exp_q.push_back(4);
    drive(1'b1, 4, 1'b0);
    drain("restart_valid");

    // restart without valid clears to phase 0.
    drive(1'b1, 9, 1'b0);
    drive(1'b0, 0, 1'b1);
    check("restart_idle_phase", int'(phase), 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(3);
      drive(1'b1, 3, 1'b0);
    end
    drain("restart_idle");

    // restart during the skip window must not disturb the skip count.
    do_reset();
    check("rst_skip_y", int'(y_out), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 77, 1'b1);
      check("skip_restart_phase", int'(phase), 0);
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(2);
      drive(1'b1, 2, 1'b0);
    end
    drain("skip_restart");

    // Reset mid-frame drops the partial sum and re-arms the skip counter.
    for (int k = 0; k < 3; k++) drive(1'b1, 20, 1'b0);
    check("pre_rst_phase", int'(phase), 3);
    do_reset();
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_phase", int'(phase), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 50, 1'b0);
      check("midrst_skip_phase", int'(phase), 0);
    end
    check("midrst_skip_y", int'(y_out), 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back(6);
      drive(1'b1, 6, 1'b0);
    end
    drain("midrst");

    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Integrate-and-dump decimator directly downstream of the FIR stage; consumes the FIR's signed output stream.
- Averages each block of 2^DEC_LOG2 valid samples and emits one scaled, optionally rounded sample with a one-cycle valid strobe.
- Discards the first SKIP valid samples after reset so the FIR warm-up output (delay line still filling) never reaches the output.

Parameters:
- BW_in, 8, width of the signed input sample (FIR output width).
- BW_out, 8, width of the signed output sample; BW_out <= BW_in is required.
- DEC_LOG2, 2, log2 of decimation factor D (D = 4).
- SKIP, 4, number of valid input samples discarded after reset (0 allowed).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- x_in  input  BW_in  signed sample from the FIR.
- in_valid  input  1  x_in is consumed on this edge when high.
- restart  input  1  synchronous frame realign: drops the partial sum.
- y_out  output  BW_out  signed decimated sample, held between strobes.
- out_valid  output  1  one-cycle pulse, y_out updated on this cycle.
- phase  output  DEC_LOG2  index of the next sample in the current frame (0..D-1).

Behaviour:
- Accumulator width ACC_W = BW_in + DEC_LOG2, so a full frame sum cannot overflow.
- Scale shift SH = DEC_LOG2 + BW_in - BW_out; output = sum >>> SH (arithmetic shift, floor).
- Reset values: y_out=0, out_valid=0, phase=0, acc=0, skip_cnt=0.
- Reset state is S_SKIP, or S_ACCUM if SKIP==0.
- S_SKIP:
  - Each in_valid increments skip_cnt.
  - On the SKIP-th valid sample, go to S_ACCUM; that sample is discarded.
  - restart is ignored in S_SKIP.
- S_ACCUM, in_valid high with phase < D-1: acc <= acc + x_in; phase++.
- S_ACCUM, in_valid high with phase == D-1:
  - y_out <= scale(acc + x_in); out_valid <= 1; acc <= 0; phase <= 0.
  - Latency: y_out is visible the cycle after the D-th sample is presented.
- in_valid low: acc, phase and y_out hold; out_valid <= 0.
- out_valid is never high for two consecutive cycles unless in_valid stays high and D == 1.
- restart in S_ACCUM:
  - Overrides frame completion; no out_valid is raised for the dropped frame.
  - If in_valid is also high, acc <= x_in and phase <= 1; otherwise acc <= 0 and phase <= 0.
- rst mid-frame: partial sum dropped, the skip counter re-arms, y_out returns to 0. rst has priority over all other inputs.
- Wrap-around: phase wraps from D-1 to 0 only on the frame-completion edge.

Optional Feature:
- Macro: FIR_DECIMATOR_ROUND_EN.
- Defined:
  - Round half up: t = (sum + 2^(SH-1)) >>> SH, computed in ACC_W+1 bits.
  - t is then saturated to the BW_out signed range; only the positive side can overflow.
  - If SH == 0, no rounding term is added.
- Undefined: plain floor truncation, no saturation logic (overflow cannot occur).

Decomposition:
- Package fir_decimator_pkg:
  - state enum {S_SKIP, S_ACCUM}.
  - Functions/localparam helpers for ACC_W and SH.
- Sub-module fir_dec_scale: purely combinational shift, round and saturate of a full frame sum.
  - Instantiated once.
  - The FIR_DECIMATOR_ROUND_EN ifdef lives only there.

Test Plan:
All cases use defaults (BW_in=8, BW_out=8, D=4, SKIP=4) unless stated.
- Warm-up and basic average: rst, then in_valid=1 continuously with inputs 99,99,99,99,10,20,30,40 -> no out_valid for the first 7 edges; out_valid pulses once with y_out=25; phase goes 0,1,2,3,0.
- Negative and rounding: frame -1,-2,-2,-1 (sum -6) -> y_out = -2 without the macro, -1 with FIR_DECIMATOR_ROUND_EN.
- Saturation (BW_out=7, ROUND_EN): frame 127,127,127,127 (sum 508, SH=3) -> y_out=63. Frame -128 x4 -> y_out=-64 both with and without the macro.
- Valid gaps: in_valid pattern 1,0,1,0,... with 8,8,8,8 after skip -> out_valid exactly once, 1 cycle after the 4th valid edge, y_out=8; y_out holds 8 afterwards with out_valid=0.
- restart: after 2 samples (5,5), assert restart with in_valid and x=4, then send 4,4,4 -> no strobe for the dropped frame; next strobe y_out=4.
  - restart asserted during S_SKIP -> no effect on the skip count.
- Reset mid-frame: rst after 3 accumulated samples -> y_out=0, phase=0; the next 4 valid samples are discarded before accumulation resumes.
